// File: rtl/osd_him_pkg.sv
// osd_him_pkg
// Shared definitions for the host interface (ingress and egress paths):
// size-field width, maximum packet length, GLIP byte order and the egress
// FSM state type.
package osd_him_pkg;

  localparam int HIM_MAX_PKT_LEN = 32;
  localparam int HIM_SIZE_W      = 5;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SIZE = 2'd1,
    DATA = 2'd2
  } him_egress_state_t;

  // GLIP words carry the high DII byte in the low GLIP byte and vice versa.
  function automatic logic [15:0] him_byteswap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/osd_him_egress_buf.sv
// osd_him_egress_buf
// Packet buffer: DEPTH x 16 register array, synchronous write, combinational
// read so the egress FSM can stream words without bubbles.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module osd_him_egress_buf
  import osd_him_pkg::*;
#(
  parameter int DEPTH = HIM_MAX_PKT_LEN
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [HIM_SIZE_W-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [HIM_SIZE_W-1:0] raddr,
  output logic [15:0]           rdata
);

  logic [15:0] mem [DEPTH];

  // Payload storage needs no reset: reads are only issued for entries
  // written by the current packet.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/osd_him_egress.sv
// osd_him_egress
// Egress half of the host interface. Buffers a complete DII packet, then
// emits a size word (flit count - 1) followed by the payload on the 16-bit
// GLIP stream, every word byte-swapped. Packets longer than BUF_SIZE are
// truncated; the excess is consumed and dropped and a sticky overflow flag
// is raised.
// Optional feature macro: OSD_HIM_EGRESS_STATS_EN adds the pkt_count port
// (16-bit wrapping count of packets fully emitted).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   dii_in_data/last/valid/ready  - DII packet input
//   glip_out_data/valid/ready     - GLIP word output toward host
//   overflow                      - sticky: a packet exceeded BUF_SIZE
//   pkt_count                     - packets emitted (stats build only)
module osd_him_egress
  import osd_him_pkg::*;
#(
  parameter int BUF_SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dii_in_data,
  input  logic        dii_in_last,
  input  logic        dii_in_valid,
  output logic        dii_in_ready,
  output logic [15:0] glip_out_data,
  output logic        glip_out_valid,
  input  logic        glip_out_ready,
  output logic        overflow
`ifdef OSD_HIM_EGRESS_STATS_EN
  ,
  output logic [15:0] pkt_count
`endif
);

  // state | meaning
  // FILL  | accepting DII flits into the buffer until last
  // SIZE  | presenting the size word on GLIP
  // DATA  | streaming buffered payload words on GLIP

  localparam int CNT_W = HIM_SIZE_W + 1;
  localparam logic [CNT_W-1:0] BUF_LIM = CNT_W'(BUF_SIZE);

  him_egress_state_t     state_q, state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [HIM_SIZE_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [HIM_SIZE_W-1:0] last_idx_q, last_idx_d;  // len - 1
  logic                  overflow_d;
  logic                  buf_we;
  logic [15:0]           buf_rdata;
`ifdef OSD_HIM_EGRESS_STATS_EN
  logic                  pkt_done;
`endif

  osd_him_egress_buf #(
    .DEPTH (BUF_SIZE)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_q[HIM_SIZE_W-1:0]),
    .wdata (dii_in_data),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      last_idx_q <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      last_idx_q <= last_idx_d;
      overflow   <= overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_ptr_d       = rd_ptr_q;
    last_idx_d     = last_idx_q;
    overflow_d     = overflow;
    buf_we         = 1'b0;
    dii_in_ready   = 1'b0;
    glip_out_valid = 1'b0;
    glip_out_data  = '0;
`ifdef OSD_HIM_EGRESS_STATS_EN
    pkt_done       = 1'b0;
`endif
    case (state_q)
      FILL: begin
        dii_in_ready = 1'b1;
        if (dii_in_valid) begin
          if (wr_cnt_q < BUF_LIM) begin
            buf_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
          // wr_cnt_d already includes this flit when it was stored, so a
          // truncated packet latches BUF_SIZE-1.
          if (dii_in_last) begin
            last_idx_d = HIM_SIZE_W'(wr_cnt_d - CNT_W'(1));
            state_d    = SIZE;
          end
        end
      end
      SIZE: begin
        glip_out_valid = 1'b1;
        glip_out_data  = him_byteswap({{(16-HIM_SIZE_W){1'b0}}, last_idx_q});
        if (glip_out_ready) begin
          rd_ptr_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        glip_out_valid = 1'b1;
        glip_out_data  = him_byteswap(buf_rdata);
        if (glip_out_ready) begin
          if (rd_ptr_q == last_idx_q) begin
            wr_cnt_d = '0;
            state_d  = FILL;
`ifdef OSD_HIM_EGRESS_STATS_EN
            pkt_done = 1'b1;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + HIM_SIZE_W'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

`ifdef OSD_HIM_EGRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (pkt_done) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_osd_him_egress.sv
// tb_osd_him_egress
// Self-checking bench for osd_him_egress (BUF_SIZE=32). Directed scenarios
// plus randomized packets checked against a packet-level reference model:
// expected GLIP stream = swap(min(n,32)-1) followed by swap of the first
// min(n,32) flits; overflow = any packet longer than 32 since reset.
module tb_osd_him_egress;

  localparam int BUF = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dii_in_data;
  logic        dii_in_last;
  logic        dii_in_valid;
  logic        dii_in_ready;
  logic [15:0] glip_out_data;
  logic        glip_out_valid;
  logic        glip_out_ready;
  logic        overflow;
`ifdef OSD_HIM_EGRESS_STATS_EN
  logic [15:0] pkt_count;
`endif

  int checks   = 0;
  int failures = 0;
  bit ovf_exp  = 1'b0;
  bit rnd_ready = 1'b0;
  bit rnd_gap   = 1'b0;
  logic ready_pat[$];

  osd_him_egress #(.BUF_SIZE(BUF)) dut (
    .clk            (clk),
    .rst            (rst),
    .dii_in_data    (dii_in_data),
    .dii_in_last    (dii_in_last),
    .dii_in_valid   (dii_in_valid),
    .dii_in_ready   (dii_in_ready),
    .glip_out_data  (glip_out_data),
    .glip_out_valid (glip_out_valid),
    .glip_out_ready (glip_out_ready),
    .overflow       (overflow)
`ifdef OSD_HIM_EGRESS_STATS_EN
    ,
    .pkt_count      (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic void model_pkt(input logic [15:0] pkt[$], output logic [15:0] exp[$]);
    int n;
    n = (pkt.size() > BUF) ? BUF : pkt.size();
    exp = {};
    exp.push_back(swap16(16'(n - 1)));
    for (int i = 0; i < n; i++) exp.push_back(swap16(pkt[i]));
  endfunction

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    dii_in_valid = 1'b0;
    dii_in_last = 1'b0;
    glip_out_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
  endtask

  // Drives flits; each flit's transfer happens at the posedge following a
  // negedge where dii_in_ready was seen high. Returns right after the last
  // transfer edge so the caller can observe first-word latency.
  task automatic send_pkt(input logic [15:0] pkt[$]);
    int w;
    for (int i = 0; i < pkt.size(); i++) begin
      if (rnd_gap) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          dii_in_valid = 1'b0;
        end
      end
      @(negedge clk);
      dii_in_valid = 1'b1;
      dii_in_data  = pkt[i];
      dii_in_last  = (i == pkt.size() - 1);
      w = 0;
      while (dii_in_ready !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) begin
        checks++; failures++;
        $display("FAIL send_timeout: dii_in_ready=%b required 1 at flit %0d", dii_in_ready, i);
      end
      @(posedge clk);
    end
  endtask

  task automatic recv(input logic [15:0] exp_in[$], input bit strict);
    logic [15:0] exp[$];
    logic [15:0] hv;
    bit held;
    int cyc;
    logic r;
    exp = exp_in;
    held = 1'b0;
    cyc = 0;
    while (exp.size() > 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      dii_in_valid = 1'b0;
      dii_in_last  = 1'b0;
      if (ready_pat.size() > 0) r = ready_pat.pop_front();
      else if (rnd_ready) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      glip_out_ready = r;
      if (held) begin
        checks++;
        if (glip_out_valid !== 1'b1 || glip_out_data !== hv) begin
          failures++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                   glip_out_valid, glip_out_data, hv);
        end
      end
      if (strict) begin
        checks++;
        if (glip_out_valid !== 1'b1) begin
          failures++;
          $display("FAIL no_bubble: valid=%b required 1 (cycle %0d)", glip_out_valid, cyc);
        end
      end
      if (glip_out_valid === 1'b1) begin
        checks++;
        if (dii_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_while_emit: dii_in_ready=%b required 0", dii_in_ready);
        end
        if (r) begin
          checks++;
          if (glip_out_data !== exp[0]) begin
            failures++;
            $display("FAIL glip_word: data=%h required %h", glip_out_data, exp[0]);
          end
          void'(exp.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1;
          hv = glip_out_data;
        end
      end
    end
    if (exp.size() > 0) begin
      checks++; failures++;
      $display("FAIL recv_timeout: %0d words missing, next required %h", exp.size(), exp[0]);
    end
  endtask

  // Block must be back in FILL with no extra word pending.
  task automatic post_check(input string name);
    @(negedge clk);
    dii_in_valid = 1'b0;
    glip_out_ready = 1'b0;
    checks++;
    if (dii_in_ready !== 1'b1 || glip_out_valid !== 1'b0 || overflow !== ovf_exp) begin
      failures++;
      $display("FAIL %s_idle: ready=%b valid=%b overflow=%b required ready=1 valid=0 overflow=%b",
               name, dii_in_ready, glip_out_valid, overflow, ovf_exp);
    end
  endtask

  task automatic run_model_pkt(input logic [15:0] pkt[$], input bit strict, input string name);
    logic [15:0] exp[$];
    model_pkt(pkt, exp);
    if (pkt.size() > BUF) ovf_exp = 1'b1;
    send_pkt(pkt);
    recv(exp, strict);
    post_check(name);
  endtask

  function automatic void rand_pkt(input int n, output logic [15:0] pkt[$]);
    pkt = {};
    for (int i = 0; i < n; i++) pkt.push_back(16'($urandom));
  endfunction

  task automatic test_reset();
    apply_reset(3);
    checks++;
    if (glip_out_valid !== 1'b0 || dii_in_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b overflow=%b required 0 1 0",
               glip_out_valid, dii_in_ready, overflow);
    end
  endtask

  task automatic test_three_flit();
    logic [15:0] pkt[$];
    logic [15:0] exp[$];
    pkt = {16'h1234, 16'h5678, 16'h9ABC};
    exp = {16'h0200, 16'h3412, 16'h7856, 16'hBC9A};
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("three_flit");
  endtask

  task automatic test_single_flit();
    logic [15:0] pkt[$];
    logic [15:0] exp[$];
    pkt = {16'hBEEF};
    exp = {16'h0000, 16'hEFBE};
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("single_flit");
  endtask

  task automatic test_backpressure();
    logic [15:0] pkt[$];
    logic [15:0] exp[$];
    pkt = {16'h0102, 16'h0304};
    exp = {16'h0100, 16'h0201, 16'h0403};
    ready_pat = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    send_pkt(pkt);
    recv(exp, 1'b0);
    post_check("backpressure");
  endtask

  task automatic test_full_oversize();
    logic [15:0] pkt[$];
    logic [15:0] exp[$];
    rand_pkt(32, pkt);
    exp = {16'h1F00};
    for (int i = 0; i < 32; i++) exp.push_back(swap16(pkt[i]));
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("full32");
    rand_pkt(33, pkt);
    exp = {16'h1F00};
    for (int i = 0; i < 32; i++) exp.push_back(swap16(pkt[i]));
    ovf_exp = 1'b1;
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("oversize33");
    pkt = {16'hCAFE, 16'hF00D};
    exp = {16'h0100, 16'hFECA, 16'h0DF0};
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("after_oversize");
  endtask

  task automatic test_reset_mid();
    logic [15:0] pkt[$];
    logic [15:0] exp[$];
    logic [15:0] part[$];
    rand_pkt(5, pkt);
    model_pkt(pkt, exp);
    send_pkt(pkt);
    for (int i = 0; i < 3; i++) part.push_back(exp[i]);
    recv(part, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    glip_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
    checks++;
    if (glip_out_valid !== 1'b0 || dii_in_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b overflow=%b required 0 1 0",
               glip_out_valid, dii_in_ready, overflow);
    end
    pkt = {16'h0A0B, 16'h0C0D};
    exp = {16'h0100, 16'h0B0A, 16'h0D0C};
    send_pkt(pkt);
    recv(exp, 1'b1);
    post_check("after_reset_mid");
  endtask

  task automatic test_random();
    logic [15:0] pkt[$];
    int n;
    rnd_ready = 1'b1;
    rnd_gap = 1'b1;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 5))
        0: n = 1;
        1: n = 32;
        2: n = 33;
        default: n = $urandom_range(1, 40);
      endcase
      rand_pkt(n, pkt);
      run_model_pkt(pkt, 1'b0, "random");
    end
    rnd_ready = 1'b0;
    rnd_gap = 1'b0;
  endtask

`ifdef OSD_HIM_EGRESS_STATS_EN
  task automatic test_stats();
    logic [15:0] pkt[$];
    apply_reset(2);
    rand_pkt(3, pkt);
    run_model_pkt(pkt, 1'b1, "stats_a1");
    rand_pkt(1, pkt);
    run_model_pkt(pkt, 1'b1, "stats_a2");
    checks++;
    if (pkt_count !== 16'd2) begin
      failures++;
      $display("FAIL pkt_count_two: pkt_count=%h required 0002", pkt_count);
    end
    @(negedge clk);
    dut.pkt_count = 16'hFFFF;
    rand_pkt(2, pkt);
    run_model_pkt(pkt, 1'b1, "stats_wrap");
    checks++;
    if (pkt_count !== 16'h0000) begin
      failures++;
      $display("FAIL pkt_count_wrap: pkt_count=%h required 0000", pkt_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    dii_in_data = '0;
    dii_in_last = 1'b0;
    dii_in_valid = 1'b0;
    glip_out_ready = 1'b0;
    test_reset();
    test_three_flit();
    test_single_flit();
    test_backpressure();
    test_full_oversize();
    test_reset_mid();
    test_random();
`ifdef OSD_HIM_EGRESS_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
